// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus single-issue sequencer in front of a registered ALU.
// Optional sticky status accumulator (and i_sticky_clr input) when ALU_SEQ_STICKY_EN is defined.
`timescale 1ns/1ps

// valid/ready: a transfer happens on a rising edge where both are high; the
// sender keeps its payload stable while valid is high and ready is low.
module alu_cmd_sequencer #(
    parameter int N       = 2,
    parameter int M       = 8,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [N-1:0] i_cmd_op,
    input  logic [M-1:0] i_cmd_A,
    input  logic [M-1:0] i_cmd_B,
    output logic [N-1:0] o_alu_op,
    output logic [M-1:0] o_alu_arg_A,
    output logic [M-1:0] o_alu_arg_B,
    input  logic [M-1:0] i_alu_result,
    input  logic [3:0]   i_alu_status,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [M-1:0] o_rsp_result,
    output logic [3:0]   o_rsp_status,
    output logic         o_busy,
`ifdef ALU_SEQ_STICKY_EN
    input  logic         i_sticky_clr,
`endif
    output logic [3:0]   o_sticky_status,
    output logic [1:0]   o_state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(ALU_LAT + 1);
    localparam int EW = N + 2 * M;
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LAT);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     wr_ptr_d;
    logic [AW:0]     rd_ptr_q;
    logic [AW:0]     rd_ptr_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   head;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    logic [N-1:0]    alu_op_q;
    logic [M-1:0]    alu_a_q;
    logic [M-1:0]    alu_b_q;
    logic            rsp_valid_q;
    logic [M-1:0]    rsp_result_q;
    logic [3:0]      rsp_status_q;
`ifdef ALU_SEQ_STICKY_EN
    logic [3:0]      sticky_q;
`endif

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign push  = i_cmd_valid && !full;
    assign pop   = (state_q == ST_IDLE) && !empty;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {i_cmd_op, i_cmd_A, i_cmd_B};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_status_q <= '0;
`ifdef ALU_SEQ_STICKY_EN
            sticky_q     <= '0;
`endif
        end else begin
`ifdef ALU_SEQ_STICKY_EN
            if (i_sticky_clr) begin
                sticky_q <= '0;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        {alu_op_q, alu_a_q, alu_b_q} <= head;
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_result_q <= i_alu_result;
                        rsp_status_q <= i_alu_status;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_HOLD;
`ifdef ALU_SEQ_STICKY_EN
                        // A coincident clear keeps only the freshly captured status.
                        sticky_q <= (i_sticky_clr ? 4'h0 : sticky_q) | i_alu_status;
`endif
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready  = !full;
    assign o_alu_op     = alu_op_q;
    assign o_alu_arg_A  = alu_a_q;
    assign o_alu_arg_B  = alu_b_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_result = rsp_result_q;
    assign o_rsp_status = rsp_status_q;
    assign o_busy       = !empty || (state_q != ST_IDLE);
    assign o_state_dbg  = state_q;
`ifdef ALU_SEQ_STICKY_EN
    assign o_sticky_status = sticky_q;
`else
    assign o_sticky_status = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a registered adder ALU stub.
// Honours ALU_SEQ_STICKY_EN in the same way as the design.
`timescale 1ns/1ps

module tb_alu_cmd_sequencer;
    localparam int N       = 2;
    localparam int M       = 8;
    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [N-1:0] cmd_op;
    logic [M-1:0] cmd_a;
    logic [M-1:0] cmd_b;
    logic [N-1:0] alu_op;
    logic [M-1:0] alu_a;
    logic [M-1:0] alu_b;
    logic [M-1:0] alu_result;
    logic [3:0]   alu_status;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [M-1:0] rsp_result;
    logic [3:0]   rsp_status;
    logic         busy;
    logic [3:0]   sticky_status;
    logic [1:0]   state_dbg;
`ifdef ALU_SEQ_STICKY_EN
    logic         sticky_clr;
`endif

    alu_cmd_sequencer #(.N(N), .M(M), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_op       (cmd_op),
        .i_cmd_A        (cmd_a),
        .i_cmd_B        (cmd_b),
        .o_alu_op       (alu_op),
        .o_alu_arg_A    (alu_a),
        .o_alu_arg_B    (alu_b),
        .i_alu_result   (alu_result),
        .i_alu_status   (alu_status),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_result   (rsp_result),
        .o_rsp_status   (rsp_status),
        .o_busy         (busy),
`ifdef ALU_SEQ_STICKY_EN
        .i_sticky_clr   (sticky_clr),
`endif
        .o_sticky_status(sticky_status),
        .o_state_dbg    (state_dbg)
    );

    // ALU stub: one registered stage, result = A+B mod 256, status = {000, carry}.
    logic [M:0] stub_sum;
    assign stub_sum = {1'b0, alu_a} + {1'b0, alu_b};
    always_ff @(posedge clk) begin
        alu_result <= stub_sum[M-1:0];
        alu_status <= {3'b000, stub_sum[M]};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [N-1:0] op;
        logic [M-1:0] a;
        logic [M-1:0] b;
    } cmd_t;

    cmd_t        m_q[$];      // commands accepted but not yet issued
    logic [11:0] exp_q[$];    // expected {status, result} of every unreleased command, in order
    int          m_eta;       // edges until the issued command's response appears (0 = none in flight)
    bit          m_hold;      // a response is being offered
    cmd_t        m_alu;       // last operands issued
    logic [3:0]  m_sticky;
    int          n_checks;
    int          n_fail;
    int          n_acc;

    function automatic logic [11:0] ref_rsp(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {3'b000, s};
    endfunction

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_eta    = 0;
        m_hold   = 1'b0;
        m_alu    = '0;
        m_sticky = 4'h0;
    endtask

    // Advance the model across one rising edge using the inputs driven before it.
    task automatic model_update();
        bit          acc;
        bit          cap;
        logic [11:0] cap_v;
        cmd_t        c;
        acc   = cmd_valid && (m_q.size() < DEPTH);
        cap   = 1'b0;
        cap_v = '0;
        if (m_hold) begin
            if (rsp_ready) begin
                m_hold = 1'b0;
                void'(exp_q.pop_front());
            end
        end else if (m_eta > 0) begin
            m_eta--;
            if (m_eta == 0) begin
                m_hold = 1'b1;
                cap    = 1'b1;
                cap_v  = exp_q[0];
            end
        end else if (m_q.size() > 0) begin
            m_alu = m_q.pop_front();
            m_eta = ALU_LAT + 1;
        end
`ifdef ALU_SEQ_STICKY_EN
        if (sticky_clr) m_sticky = cap ? cap_v[11:8] : 4'h0;
        else if (cap)   m_sticky = m_sticky | cap_v[11:8];
`else
        if (cap) m_sticky = 4'h0;
`endif
        if (acc) begin
            c.op = cmd_op;
            c.a  = cmd_a;
            c.b  = cmd_b;
            m_q.push_back(c);
            exp_q.push_back(ref_rsp(cmd_a, cmd_b));
            n_acc++;
        end
    endtask

    // Inputs change after a falling edge; outputs are sampled at the falling edge.
    task automatic tick();
        if (rst_n) model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!busy && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [38:0] got;
        #1;
        got = {cmd_ready, rsp_valid, busy, rsp_result, rsp_status, alu_op, alu_a, alu_b, sticky_status, state_dbg};
        n_checks++;
        if (got !== {1'b1, 38'h0}) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=%h", got, {1'b1, 38'h0});
        end
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        n_checks++;
        if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL after_release got=%b exp=100", {cmd_ready, rsp_valid, busy});
        end
    endtask

    task automatic test_single();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'h02; cmd_b = 8'h03;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready got=%b exp=1", cmd_ready);
        end
        tick();                       // E0: accepted
        cmd_valid = 1'b0;
        tick();                       // E0+1: operands issued
        n_checks++;
        if ({alu_op, alu_a, alu_b} !== {2'b00, 8'h02, 8'h03}) begin
            n_fail++;
            $display("FAIL single_operands got=%h exp=%h", {alu_op, alu_a, alu_b}, {2'b00, 8'h02, 8'h03});
        end
        tick();                       // E0+2
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early_valid got=%b exp=0", rsp_valid);
        end
        tick();                       // E0+3: response captured
        n_checks++;
        if ({rsp_valid, rsp_result, rsp_status} !== {1'b1, 8'h05, 4'b0000}) begin
            n_fail++;
            $display("FAIL single_rsp got=%h exp=%h", {rsp_valid, rsp_result, rsp_status}, {1'b1, 8'h05, 4'b0000});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_done got=%b exp=00", {rsp_valid, busy});
        end
    endtask

    task automatic test_carry();
        int lat;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_a = 8'hFF; cmd_b = 8'h01;
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== ALU_LAT + 3) begin
            n_fail++;
            $display("FAIL carry_latency got=%0d exp=%0d", lat, ALU_LAT + 3);
        end
        n_checks++;
        if ({rsp_valid, rsp_result, rsp_status} !== {1'b1, 8'h00, 4'b0001}) begin
            n_fail++;
            $display("FAIL carry_rsp got=%h exp=%h", {rsp_valid, rsp_result, rsp_status}, {1'b1, 8'h00, 4'b0001});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  k;
        int  acc;
        bit  rdy;
        rsp_ready = 1'b0;
        k   = 1;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'(k); cmd_b = 8'h00;
            rdy = cmd_ready;
            if (rsp_valid) begin
                n_checks++;
                if (rsp_result !== 8'h01) begin
                    n_fail++;
                    $display("FAIL b2b_hold_stable cyc=%0d got=%h exp=01", c, rsp_result);
                end
            end
            tick();
            if (rdy) begin
                acc++;
                if (k < 6) k++;
            end
        end
        n_checks++;
        if (acc !== 5) begin
            n_fail++;
            $display("FAIL b2b_accepted got=%0d exp=5", acc);
        end
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_result} !== {1'b0, 1'b1, 8'h01}) begin
            n_fail++;
            $display("FAIL b2b_full_hold got=%h exp=%h", {cmd_ready, rsp_valid, rsp_result}, {1'b0, 1'b1, 8'h01});
        end
    endtask

    // FIFO full and HOLD released on the same edge: the release edge accepts nothing;
    // the following edge pops the head, and only the edge after that sees ready high.
    task automatic test_full_release();
        int waited;
        bit rdy;
        rsp_ready = 1'b1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL release_edge_ready got=%b exp=0", cmd_ready);
        end
        tick();
        waited = 0;
        rdy    = 1'b0;
        while (!rdy && waited < 8) begin
            rdy = cmd_ready;
            tick();
            waited++;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (!rdy || waited !== 2) begin
            n_fail++;
            $display("FAIL release_accept_edge got=%0d exp=2", rdy ? waited : -1);
        end
    endtask

    task automatic test_drain();
        logic [M-1:0] got[$];
        bit           done;
        rsp_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (!busy && !rsp_valid) begin
                done = 1'b1;
                break;
            end
            if (rsp_valid) got.push_back(rsp_result);
            tick();
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain_busy_fall got=busy exp=idle");
        end
        n_checks++;
        if (got.size() !== 5) begin
            n_fail++;
            $display("FAIL drain_count got=%0d exp=5", got.size());
        end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            n_checks++;
            if (got[i] !== 8'(i + 2)) begin
                n_fail++;
                $display("FAIL drain_order idx=%0d got=%h exp=%h", i, got[i], 8'(i + 2));
            end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        logic [38:0] got;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 8'h10; cmd_b = 8'h20;
        tick();
        cmd_valid = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midwait_busy got=%b exp=1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {cmd_ready, rsp_valid, busy, rsp_result, rsp_status, alu_op, alu_a, alu_b, sticky_status, state_dbg};
        n_checks++;
        if (got !== {1'b1, 38'h0}) begin
            n_fail++;
            $display("FAIL async_reset got=%h exp=%h", got, {1'b1, 38'h0});
        end
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({rsp_valid, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL post_reset_quiet cyc=%0d got=%b exp=00", c, {rsp_valid, busy});
            end
        end
    endtask

    task automatic test_sticky();
        bit ok;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'hFF; cmd_b = 8'h01;
        tick();
        cmd_valid = 1'b0;
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sticky_idle1 got=busy exp=idle");
        end
        cmd_valid = 1'b1; cmd_a = 8'h01; cmd_b = 8'h01;
        tick();
        cmd_valid = 1'b0;
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sticky_idle2 got=busy exp=idle");
        end
`ifdef ALU_SEQ_STICKY_EN
        n_checks++;
        if (sticky_status !== 4'b0001) begin
            n_fail++;
            $display("FAIL sticky_accum got=%b exp=0001", sticky_status);
        end
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        n_checks++;
        if (sticky_status !== 4'b0000) begin
            n_fail++;
            $display("FAIL sticky_clear got=%b exp=0000", sticky_status);
        end
`else
        n_checks++;
        if (sticky_status !== 4'b0000) begin
            n_fail++;
            $display("FAIL sticky_tied got=%b exp=0000", sticky_status);
        end
`endif
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        bit         pend;
        bit         rdy_pre;
        logic [2:0] flags_exp;
        pend = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            flags_exp = {m_q.size() < DEPTH, m_hold, (m_q.size() > 0) || m_hold || (m_eta > 0)};
            n_checks++;
            if ({cmd_ready, rsp_valid, busy} !== flags_exp) begin
                n_fail++;
                $display("FAIL rand_flags cyc=%0d got=%b exp=%b", cyc, {cmd_ready, rsp_valid, busy}, flags_exp);
            end
            n_checks++;
            if ({alu_op, alu_a, alu_b} !== m_alu) begin
                n_fail++;
                $display("FAIL rand_operands cyc=%0d got=%h exp=%h", cyc, {alu_op, alu_a, alu_b}, m_alu);
            end
            if (m_hold) begin
                n_checks++;
                if ({rsp_status, rsp_result} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rand_rsp cyc=%0d got=%h exp=%h", cyc, {rsp_status, rsp_result}, exp_q[0]);
                end
            end
            n_checks++;
            if (sticky_status !== m_sticky) begin
                n_fail++;
                $display("FAIL rand_sticky cyc=%0d got=%b exp=%b", cyc, sticky_status, m_sticky);
            end
            if (!pend) begin
                cmd_valid = ($urandom_range(0, 99) < 60);
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_a     = 8'($urandom_range(0, 255));
                cmd_b     = 8'($urandom_range(0, 255));
            end
            rsp_ready = ($urandom_range(0, 99) < 40);
`ifdef ALU_SEQ_STICKY_EN
            sticky_clr = ($urandom_range(0, 15) == 0);
`endif
            rdy_pre = cmd_ready;
            tick();
            pend = cmd_valid && !rdy_pre;
        end
        cmd_valid = 1'b0;
`ifdef ALU_SEQ_STICKY_EN
        sticky_clr = 1'b0;
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
`ifdef ALU_SEQ_STICKY_EN
        sticky_clr = 1'b0;
`endif
        n_checks = 0;
        n_fail   = 0;
        n_acc    = 0;
        model_reset();

        test_reset();
        test_single();
        test_carry();
        test_back_to_back();
        test_full_release();
        test_drain();
        test_reset_mid_wait();
        test_sticky();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
